uart_rx_fifo: RTL and testbench

// - Receive buffer directly downstream of uart_rx: captures each completed byte
//   (rx_data, rx_idle, rx_error) into a DEPTH-entry synchronous FIFO.
// - Lets the consumer (command parser / CPU bus) read bytes at its own pace.
// - Reports FIFO status, overflow and framing-error statistics.

---
 rtl/uart_rx_fifo.sv | 106 ++++++++++
 tb/tb_uart_rx_fifo.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind uart_rx: detects each completed frame on the rising edge
// of rx_idle, queues good bytes in a DEPTH-entry FIFO and tracks overflow and framing-error statistics.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk50m,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] rx_data,
  input  logic             rx_idle,
  input  logic             rx_error,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count,
  output logic             overflow,
  input  logic             ovf_clr,
  output logic [7:0]       err_cnt
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic             idle_q, idle_d;
  logic             done, rd_ok, wr_ok, drop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign count    = count_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign overflow = overflow_q;
  assign err_cnt  = err_cnt_q;

  always_comb begin
    done  = rx_idle & ~idle_q;
    rd_ok = rd_en & ~empty;
    // A full FIFO still accepts a byte when a read frees a slot in the same cycle.
    wr_ok = done & ~rx_error & (~full | rd_ok);
    drop  = done & ~rx_error & full & ~rd_ok;

    idle_d     = rx_idle;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_ok;
    overflow_d = overflow_q;
    err_cnt_d  = err_cnt_q;

    if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_ok) begin
      rd_ptr_d  = rd_ptr_q + AW'(1);
      rd_data_d = mem_q[rd_ptr_q];
    end

    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (drop)         overflow_d = 1'b1;
    else if (ovf_clr) overflow_d = 1'b0;

    if (done && rx_error && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      idle_q     <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      overflow_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      idle_q     <= idle_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      overflow_q <= overflow_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // Storage carries no reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk50m) begin
    if (wr_ok) mem_q[wr_ptr_q] <= rx_data;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: frame-complete edges are generated directly on
// rx_idle and every expected value is hand-derived or taken from a small byte queue.
module tb_uart_rx_fifo;

  logic       clk50m = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_idle;
  logic       rx_error;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overflow;
  logic       ovf_clr;
  logic [7:0] err_cnt;

  int n_chk = 0;
  int n_err = 0;
  logic [7:0] model_q[$];
  logic [7:0] exp_b;

  uart_rx_fifo #(.WIDTH(8), .DEPTH(16)) dut (
    .clk50m(clk50m), .rst_n(rst_n), .rx_data(rx_data), .rx_idle(rx_idle),
    .rx_error(rx_error), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .empty(empty), .full(full), .count(count), .overflow(overflow),
    .ovf_clr(ovf_clr), .err_cnt(err_cnt)
  );

  always #10 clk50m = ~clk50m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk50m);
    #1;
  endtask

  // One frame: rx_idle low for a cycle, then high; rd/clr are asserted on the done edge.
  task automatic send(input logic [7:0] d, input logic e, input logic rd, input logic clr);
    rx_data  = d;
    rx_error = e;
    rx_idle  = 1'b0;
    tick();
    rx_idle = 1'b1;
    rd_en   = rd;
    ovf_clr = clr;
    tick();
    rd_en   = 1'b0;
    ovf_clr = 1'b0;
    rx_error = 1'b0;
  endtask

  task automatic read_one(input string tag, input logic [7:0] exp);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk({tag, "_vld"}, rd_valid, 1);
    chk({tag, "_dat"}, rd_data, exp);
  endtask

  initial begin
    rst_n = 1'b0; rx_data = 8'h00; rx_idle = 1'b1; rx_error = 1'b0;
    rd_en = 1'b0; ovf_clr = 1'b0;
    repeat (3) tick();
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_rdvld", rd_valid, 0);
    chk("rst_rddat", rd_data, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_errcnt", err_cnt, 0);
    @(negedge clk50m) rst_n = 1'b1;
    repeat (2) tick();
    chk("no_false_edge", count, 0);

    send(8'hA5, 1'b0, 1'b0, 1'b0);
    chk("a5_empty", empty, 0);
    chk("a5_count", count, 1);
    read_one("a5_rd", 8'hA5);
    chk("a5_empty_after", empty, 1);
    tick();
    chk("a5_vld_pulse", rd_valid, 0);

    for (int i = 0; i < 16; i++) send(8'(i), 1'b0, 1'b0, 1'b0);
    chk("fill_full", full, 1);
    chk("fill_count", count, 16);
    chk("fill_ovf0", overflow, 0);
    send(8'h10, 1'b0, 1'b0, 1'b0);
    chk("ovf_set", overflow, 1);
    chk("ovf_count", count, 16);
    send(8'h11, 1'b0, 1'b0, 1'b1);
    chk("ovf_set_beats_clr", overflow, 1);
    for (int i = 0; i < 16; i++) read_one($sformatf("drain%0d", i), 8'(i));
    chk("drain_empty", empty, 1);
    chk("drain_count", count, 0);

    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("rd_empty_vld", rd_valid, 0);
    chk("rd_empty_dat", rd_data, 8'h0F);
    chk("rd_empty_count", count, 0);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_clr", overflow, 0);

    send(8'h77, 1'b1, 1'b0, 1'b0);
    chk("err_cnt1", err_cnt, 1);
    chk("err_count_fifo", count, 0);
    for (int i = 0; i < 299; i++) send(8'h77, 1'b1, 1'b0, 1'b0);
    chk("err_sat", err_cnt, 255);
    chk("err_empty", empty, 1);

    send(8'h3C, 1'b0, 1'b1, 1'b0);
    chk("wr_rd_empty_vld", rd_valid, 0);
    chk("wr_rd_empty_count", count, 1);
    read_one("wr_rd_empty_rd", 8'h3C);

    for (int i = 0; i < 16; i++) send(8'h20 + 8'(i), 1'b0, 1'b0, 1'b0);
    chk("full2", full, 1);
    send(8'h55, 1'b0, 1'b1, 1'b0);
    chk("full_wr_rd_vld", rd_valid, 1);
    chk("full_wr_rd_dat", rd_data, 8'h20);
    chk("full_wr_rd_count", count, 16);
    chk("full_wr_rd_ovf", overflow, 0);
    for (int i = 1; i < 16; i++) read_one($sformatf("full2_rd%0d", i), 8'h20 + 8'(i));
    read_one("full2_last", 8'h55);
    chk("full2_empty", empty, 1);

    model_q.delete();
    for (int i = 0; i < 20; i++) begin
      send(8'h80 + 8'(i), 1'b0, 1'b0, 1'b0);
      model_q.push_back(8'h80 + 8'(i));
      if (i % 2 == 1) begin
        exp_b = model_q.pop_front();
        read_one($sformatf("wrap_rd%0d", i), exp_b);
      end
    end
    chk("wrap_count", count, 10);
    while (model_q.size() > 0) begin
      exp_b = model_q.pop_front();
      read_one("wrap_drain", exp_b);
    end
    chk("wrap_empty", empty, 1);
    chk("wrap_ovf", overflow, 0);

    for (int i = 0; i < 3; i++) send(8'hE0 + 8'(i), 1'b0, 1'b0, 1'b0);
    send(8'h01, 1'b1, 1'b0, 1'b0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    #3 rst_n = 1'b0;
    #2;
    chk("midrst_count", count, 0);
    chk("midrst_empty", empty, 1);
    chk("midrst_errcnt", err_cnt, 0);
    chk("midrst_rddat", rd_data, 0);
    chk("midrst_vld", rd_valid, 0);
    @(negedge clk50m) rst_n = 1'b1;
    tick();
    send(8'h9A, 1'b0, 1'b0, 1'b0);
    read_one("post_rst_rd", 8'h9A);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
